// File: rtl/bcd_entry_reg_if.sv
// bcd_entry_reg_if: keypad-strobe and operand-output bundle for bcd_entry_reg.
// Parameters: DIGITS (BCD digits held), CW (digit_count width).
// Inputs to the register: keycode, keystrobe, bksp_strobe, clear_strobe, commit_strobe.
// Outputs from the register: bcd_out, digit_valid, digit_count, full, locked,
// key_accepted, key_rejected, and negative when NEG_SIGN_EN is defined.
interface bcd_entry_reg_if #(
    parameter int DIGITS = 3,
    parameter int CW     = 4
);
    logic [3:0]          keycode;
    logic                keystrobe;
    logic                bksp_strobe;
    logic                clear_strobe;
    logic                commit_strobe;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   digit_valid;
    logic [CW-1:0]       digit_count;
    logic                full;
    logic                locked;
    logic                key_accepted;
    logic                key_rejected;
`ifdef NEG_SIGN_EN
    logic                negative;
    modport master (
        output keycode, keystrobe, bksp_strobe, clear_strobe, commit_strobe,
        input  bcd_out, digit_valid, digit_count, full, locked,
               key_accepted, key_rejected, negative
    );
    modport slave (
        input  keycode, keystrobe, bksp_strobe, clear_strobe, commit_strobe,
        output bcd_out, digit_valid, digit_count, full, locked,
               key_accepted, key_rejected, negative
    );
`else
    modport master (
        output keycode, keystrobe, bksp_strobe, clear_strobe, commit_strobe,
        input  bcd_out, digit_valid, digit_count, full, locked,
               key_accepted, key_rejected
    );
    modport slave (
        input  keycode, keystrobe, bksp_strobe, clear_strobe, commit_strobe,
        output bcd_out, digit_valid, digit_count, full, locked,
               key_accepted, key_rejected
    );
`endif
endinterface

// File: rtl/bcd_entry_reg.sv
// bcd_entry_reg: decimal operand-entry register with backspace, clear, commit/lock
// and leading-zero suppression.
// Ports: clock, reset (async active-high), bus (bcd_entry_reg_if.slave) carrying
// keypad strobes in and packed BCD, blanking mask, count and key pulses out.
// Optional macro NEG_SIGN_EN adds the negative sign flag toggled by keycode 4'hF.
module bcd_entry_reg #(
    parameter int DIGITS = 3,
    parameter int CW     = 4
) (
    input logic           clock,
    input logic           reset,
    bcd_entry_reg_if.slave bus
);
    localparam int W = 4 * DIGITS;
    typedef enum logic [1:0] {EMPTY, ENTRY, FULL, LOCKED} state_t;
    state_t        state;
    logic [W-1:0]  bcd;
    logic [CW-1:0] count;
    logic          acc;
    logic          rej;
`ifdef NEG_SIGN_EN
    logic          neg;
`endif
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            bcd   <= '0;
            count <= '0;
            acc   <= 1'b0;
            rej   <= 1'b0;
`ifdef NEG_SIGN_EN
            neg   <= 1'b0;
`endif
        end else begin
            acc <= 1'b0;
            rej <= 1'b0;
            if (bus.clear_strobe) begin
                state <= EMPTY;
                bcd   <= '0;
                count <= '0;
`ifdef NEG_SIGN_EN
                neg   <= 1'b0;
`endif
            end else if (bus.commit_strobe) begin
                state <= LOCKED;
            end else if (bus.bksp_strobe) begin
                if (state == ENTRY || state == FULL) begin
                    bcd   <= bcd >> 4;
                    count <= count - CW'(1);
                    state <= (count == CW'(1)) ? EMPTY : ENTRY;
                end
            end else if (bus.keystrobe) begin
                if (bus.keycode <= 4'd9) begin
                    // LOCKED restarts the entry, so it loads exactly like EMPTY;
                    // a leading 0 is accepted but leaves the register empty.
                    if (state == EMPTY || state == LOCKED) begin
                        bcd   <= W'(bus.keycode);
                        count <= (bus.keycode == 4'd0) ? CW'(0) : CW'(1);
                        state <= (bus.keycode == 4'd0) ? EMPTY : (DIGITS == 1) ? FULL : ENTRY;
                        acc   <= 1'b1;
                    end else if (state == ENTRY) begin
                        bcd   <= (bcd << 4) | W'(bus.keycode);
                        count <= count + CW'(1);
                        state <= (count + CW'(1) == CW'(DIGITS)) ? FULL : ENTRY;
                        acc   <= 1'b1;
                    end else begin
                        rej   <= 1'b1;
                    end
`ifdef NEG_SIGN_EN
                end else if (bus.keycode == 4'hF) begin
                    acc <= 1'b1;
                    if (state == LOCKED) begin
                        state <= EMPTY;
                        bcd   <= '0;
                        count <= '0;
                        neg   <= 1'b1;
                    end else begin
                        neg   <= ~neg;
                    end
`endif
                end else begin
                    rej <= 1'b1;
                end
            end
        end
    end
    assign bus.bcd_out      = bcd;
    assign bus.digit_count  = count;
    assign bus.full         = (count == CW'(DIGITS));
    assign bus.locked       = (state == LOCKED);
    assign bus.key_accepted = acc;
    assign bus.key_rejected = rej;
`ifdef NEG_SIGN_EN
    assign bus.negative     = neg;
`endif
    // Digit 0 always shows so an empty entry displays "0".
    for (genvar i = 0; i < DIGITS; i++) begin : g_dv
        assign bus.digit_valid[i] = (i == 0) || (CW'(i) < count);
    end
endmodule

// File: tb/tb_bcd_entry_reg.sv
// tb_bcd_entry_reg: directed scoreboard bench for bcd_entry_reg (DIGITS=3 and DIGITS=6).
module tb_bcd_entry_reg;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bcd_entry_reg_if #(.DIGITS(3), .CW(4)) ia ();
    bcd_entry_reg_if #(.DIGITS(6), .CW(4)) ib ();
    bcd_entry_reg #(.DIGITS(3), .CW(4)) dut_a (.clock(clock), .reset(reset), .bus(ia));
    bcd_entry_reg #(.DIGITS(6), .CW(4)) dut_b (.clock(clock), .reset(reset), .bus(ib));

`ifdef NEG_SIGN_EN
    localparam logic FNEG = 1'b1;
`else
    localparam logic FNEG = 1'b0;
`endif

    typedef struct {
        string       tag;
        int          sel;
        logic [23:0] bcd;
        logic [3:0]  cnt;
        logic        lk;
        logic        acc;
        logic        rej;
        logic        neg;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ia.keycode = 4'd0; ia.keystrobe = 1'b0; ia.bksp_strobe = 1'b0;
        ia.clear_strobe = 1'b0; ia.commit_strobe = 1'b0;
        ib.keycode = 4'd0; ib.keystrobe = 1'b0; ib.bksp_strobe = 1'b0;
        ib.clear_strobe = 1'b0; ib.commit_strobe = 1'b0;
    endtask

    task automatic check_out(input exp_t e);
        logic [5:0] exp_dv;
        int digits;
        digits = (e.sel == 0) ? 3 : 6;
        for (int i = 0; i < 6; i++) exp_dv[i] = (i < digits) && ((i == 0) || (i < int'(e.cnt)));
        if (e.sel == 0) begin
            chk({e.tag, ".bcd"},  32'(ia.bcd_out), 32'(e.bcd));
            chk({e.tag, ".cnt"},  32'(ia.digit_count), 32'(e.cnt));
            chk({e.tag, ".dv"},   32'(ia.digit_valid), 32'(exp_dv));
            chk({e.tag, ".full"}, 32'(ia.full), 32'(int'(e.cnt) == digits));
            chk({e.tag, ".lk"},   32'(ia.locked), 32'(e.lk));
            chk({e.tag, ".acc"},  32'(ia.key_accepted), 32'(e.acc));
            chk({e.tag, ".rej"},  32'(ia.key_rejected), 32'(e.rej));
`ifdef NEG_SIGN_EN
            chk({e.tag, ".neg"},  32'(ia.negative), 32'(e.neg));
`endif
        end else begin
            chk({e.tag, ".bcd"},  32'(ib.bcd_out), 32'(e.bcd));
            chk({e.tag, ".cnt"},  32'(ib.digit_count), 32'(e.cnt));
            chk({e.tag, ".dv"},   32'(ib.digit_valid), 32'(exp_dv));
            chk({e.tag, ".full"}, 32'(ib.full), 32'(int'(e.cnt) == digits));
            chk({e.tag, ".lk"},   32'(ib.locked), 32'(e.lk));
            chk({e.tag, ".acc"},  32'(ib.key_accepted), 32'(e.acc));
            chk({e.tag, ".rej"},  32'(ib.key_rejected), 32'(e.rej));
`ifdef NEG_SIGN_EN
            chk({e.tag, ".neg"},  32'(ib.negative), 32'(e.neg));
`endif
        end
    endtask

    // Drive one cycle of strobes, queue the expectation, compare after the edge.
    task automatic step(input string tag, input int sel, input logic [3:0] k,
                        input logic ks, input logic bk, input logic cl, input logic cm,
                        input logic [23:0] bcd, input logic [3:0] cnt,
                        input logic lk, input logic acc, input logic rej,
                        input logic neg = 1'b0);
        exp_t e;
        if (sel == 0) begin
            ia.keycode = k; ia.keystrobe = ks; ia.bksp_strobe = bk;
            ia.clear_strobe = cl; ia.commit_strobe = cm;
        end else begin
            ib.keycode = k; ib.keystrobe = ks; ib.bksp_strobe = bk;
            ib.clear_strobe = cl; ib.commit_strobe = cm;
        end
        e = '{tag, sel, bcd, cnt, lk, acc, rej, neg};
        sb.push_back(e);
        @(posedge clock);
        #1;
        idle();
        check_out(sb.pop_front());
    endtask

    initial begin
        exp_t r;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        r = '{"rst_a", 0, 24'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        check_out(r);
        reset = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #1;
        // keys 1,2,3 fill the register
        step("k1",    0, 4'd1, 1, 0, 0, 0, 24'h001, 4'd1, 0, 1, 0);
        step("k2",    0, 4'd2, 1, 0, 0, 0, 24'h012, 4'd2, 0, 1, 0);
        step("k3",    0, 4'd3, 1, 0, 0, 0, 24'h123, 4'd3, 0, 1, 0);
        step("hold",  0, 4'd0, 0, 0, 0, 0, 24'h123, 4'd3, 0, 0, 0);
        step("k4full",0, 4'd4, 1, 0, 0, 0, 24'h123, 4'd3, 0, 0, 1);
        step("bksp",  0, 4'd0, 0, 1, 0, 0, 24'h012, 4'd2, 0, 0, 0);
        step("kB",    0, 4'hB, 1, 0, 0, 0, 24'h012, 4'd2, 0, 0, 1);
        step("clr",   0, 4'd0, 0, 0, 1, 0, 24'h000, 4'd0, 0, 0, 0);
        // leading zero suppression
        step("z0",    0, 4'd0, 1, 0, 0, 0, 24'h000, 4'd0, 0, 1, 0);
        step("z1",    0, 4'd0, 1, 0, 0, 0, 24'h000, 4'd0, 0, 1, 0);
        step("k7",    0, 4'd7, 1, 0, 0, 0, 24'h007, 4'd1, 0, 1, 0);
        step("clr2",  0, 4'd0, 0, 0, 1, 0, 24'h000, 4'd0, 0, 0, 0);
        // commit / lock behaviour
        step("k4",    0, 4'd4, 1, 0, 0, 0, 24'h004, 4'd1, 0, 1, 0);
        step("k5",    0, 4'd5, 1, 0, 0, 0, 24'h045, 4'd2, 0, 1, 0);
        step("cmt",   0, 4'd0, 0, 0, 0, 1, 24'h045, 4'd2, 1, 0, 0);
        step("bk_lk", 0, 4'd0, 0, 1, 0, 0, 24'h045, 4'd2, 1, 0, 0);
        step("cmt2",  0, 4'd0, 0, 0, 0, 1, 24'h045, 4'd2, 1, 0, 0);
        step("kA_lk", 0, 4'hA, 1, 0, 0, 0, 24'h045, 4'd2, 1, 0, 1);
        step("k9_lk", 0, 4'd9, 1, 0, 0, 0, 24'h009, 4'd1, 0, 1, 0);
        // priority
        step("clr_k5",0, 4'd5, 1, 0, 1, 0, 24'h000, 4'd0, 0, 0, 0);
        step("k1b",   0, 4'd1, 1, 0, 0, 0, 24'h001, 4'd1, 0, 1, 0);
        step("k2b",   0, 4'd2, 1, 0, 0, 0, 24'h012, 4'd2, 0, 1, 0);
        step("cm_bk", 0, 4'd3, 1, 1, 0, 1, 24'h012, 4'd2, 1, 0, 0);
        step("k0_lk", 0, 4'd0, 1, 0, 0, 0, 24'h000, 4'd0, 0, 1, 0);
        step("bk_key",0, 4'd6, 1, 1, 0, 0, 24'h000, 4'd0, 0, 0, 0);
        step("k8",    0, 4'd8, 1, 0, 0, 0, 24'h008, 4'd1, 0, 1, 0);
        step("bk_e",  0, 4'd0, 0, 1, 0, 0, 24'h000, 4'd0, 0, 0, 0);
        step("bk_und",0, 4'd0, 0, 1, 0, 0, 24'h000, 4'd0, 0, 0, 0);
        step("kF_a",  0, 4'hF, 1, 0, 0, 0, 24'h000, 4'd0, 0, FNEG, !FNEG, FNEG);
        step("clr3",  0, 4'd0, 0, 0, 1, 0, 24'h000, 4'd0, 0, 0, 0);
        // asynchronous reset mid-entry, observed before the next edge
        step("k5m",   0, 4'd5, 1, 0, 0, 0, 24'h005, 4'd1, 0, 1, 0);
        step("k6m",   0, 4'd6, 1, 0, 0, 0, 24'h056, 4'd2, 0, 1, 0);
        #3 reset = 1'b1;
        #1;
        r = '{"arst", 0, 24'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        check_out(r);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        // six-digit instance
        step("b9", 1, 4'd9, 1, 0, 0, 0, 24'h000009, 4'd1, 0, 1, 0);
        step("b8", 1, 4'd8, 1, 0, 0, 0, 24'h000098, 4'd2, 0, 1, 0);
        step("b7", 1, 4'd7, 1, 0, 0, 0, 24'h000987, 4'd3, 0, 1, 0);
        step("b6", 1, 4'd6, 1, 0, 0, 0, 24'h009876, 4'd4, 0, 1, 0);
        step("b5", 1, 4'd5, 1, 0, 0, 0, 24'h098765, 4'd5, 0, 1, 0);
        step("b4", 1, 4'd4, 1, 0, 0, 0, 24'h987654, 4'd6, 0, 1, 0);
        step("bA", 1, 4'hA, 1, 0, 0, 0, 24'h987654, 4'd6, 0, 0, 1);
        step("b3", 1, 4'd3, 1, 0, 0, 0, 24'h987654, 4'd6, 0, 0, 1);
        step("bF", 1, 4'hF, 1, 0, 0, 0, 24'h987654, 4'd6, 0, FNEG, !FNEG, FNEG);
        step("bbk",1, 4'd0, 0, 1, 0, 0, 24'h098765, 4'd5, 0, 0, 0, FNEG);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
